// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO behind a UART receiver with a sticky overflow flag
// and a saturating receive-error counter.
module uart_rx_fifo #(
   parameter int DEPTH    = 16,
   parameter int ERR_BITS = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_received,
   input  logic [7:0]                 i_rx_byte,
   input  logic                       i_recv_error,
   input  logic                       i_rd_en,
   input  logic                       i_clear_flags,
   output logic [7:0]                 o_rd_data,
   output logic                       o_empty,
   output logic                       o_full,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   output logic [ERR_BITS-1:0]        o_err_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]          r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [CW-1:0]       r_count;
   logic                r_overflow;
   logic [ERR_BITS-1:0] r_err_cnt;
   logic                w_byte;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;

   assign o_empty     = r_count == '0;
   assign o_full      = r_count == CW'(DEPTH);
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;
   assign o_err_count = r_err_cnt;
   assign o_rd_data   = o_empty ? 8'h00 : r_mem[r_rd_ptr];

   // An error strobe wins over a same-cycle byte strobe.
   assign w_byte = i_received & ~i_recv_error;
   assign w_pop  = i_rd_en & ~o_empty;
   assign w_push = w_byte & (~o_full | w_pop);
   assign w_drop = w_byte & o_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_rx_byte;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_err_cnt  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (i_clear_flags) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= '0;
         end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (i_recv_error && r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_BITS'(1);
         end
      end
   end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, byte capacity of the FIFO; SHALL be a power of two, minimum 2.
REQ-002 Parameter ERR_BITS, default 8, width of the saturating receive-error counter.
REQ-003 clk  input  1  master clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 received  input  1  one-cycle strobe from the upstream UART receiver: rx_byte is valid.
REQ-006 rx_byte  input  8  byte from the upstream receiver; sampled only when received=1.
REQ-007 recv_error  input  1  one-cycle strobe from the upstream receiver: framing/start error.
REQ-008 rd_en  input  1  consumer pop request.
REQ-009 clear_flags  input  1  synchronous clear of overflow and err_count.
REQ-010 rd_data  output  8  head-of-FIFO byte (first-word-fall-through).
REQ-011 empty  output  1  FIFO holds zero bytes.
REQ-012 full  output  1  FIFO holds DEPTH bytes.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag: a received byte was dropped.
REQ-015 err_count  output  ERR_BITS  saturating count of recv_error strobes.

Function
REQ-016 Storage SHALL be a DEPTH x 8 array with write and read pointers of $clog2(DEPTH) bits; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 Write: when received=1 and recv_error=0, and either full=0 or a pop is accepted in the same cycle, rx_byte SHALL be stored at the write pointer and the write pointer SHALL advance by one.
REQ-018 A pop SHALL be accepted when rd_en=1 and empty=0; the read pointer SHALL then advance by one.
REQ-019 rd_en while empty=1 SHALL be ignored: no pointer change, no flag change, no underflow indication.
REQ-020 rd_data SHALL equal the byte at the read pointer while empty=0, and 8'h00 while empty=1; it SHALL present a newly written byte in the cycle after the write (zero-cycle fall-through latency is not required).
REQ-021 count SHALL be +1 on a write only, -1 on a pop only, and unchanged on a simultaneous write and pop, including at count=0 (write only, because the pop is ignored) and at count=DEPTH (both succeed).
REQ-022 empty SHALL be (count==0) and full SHALL be (count==DEPTH), both registered or derived from registered count, with no combinational path from inputs.
REQ-023 received=1 while full=1 with no accepted pop SHALL drop the byte, leave the storage and pointers unchanged, and set overflow to 1 on the next edge.
REQ-024 recv_error=1 SHALL increment err_count by one, saturating at 2^ERR_BITS-1; a byte SHALL never be written on that cycle.
REQ-025 received=1 and recv_error=1 together SHALL be treated as an error only: the counter increments and the byte is dropped without setting overflow.
REQ-026 clear_flags=1 SHALL clear overflow and err_count on the next edge and SHALL take priority over a same-cycle set or increment; the FIFO contents SHALL be unaffected.
REQ-027 The block SHALL rely on received and recv_error being single-cycle strobes; a strobe held high for N cycles SHALL be treated as N events.

Reset
REQ-028 While rst_n=0, pointers, count, overflow and err_count SHALL be held at 0, empty=1, full=0 and rd_data=8'h00, independent of clk.
REQ-029 Storage array contents SHALL NOT be reset; they are unobservable while empty=1.
REQ-030 Asserting reset mid-operation SHALL discard all buffered bytes; the first write after reset release SHALL land in entry 0.
REQ-031 Reset release SHALL be synchronised externally; inputs are ignored until the first clk edge with rst_n=1.

Verification
REQ-032 Strobe 0x41, 0x42, 0x43 with received, then rd_en for 3 cycles -> rd_data reads 0x41, 0x42, 0x43 in order; count goes 3,2,1,0; empty=1 at the end.
REQ-033 Write DEPTH=16 bytes 0x00..0x0F, then a 17th byte 0xAA -> full=1, overflow=1, count=16; pops return 0x00..0x0F and 0xAA never appears.
REQ-034 At full, received=0x55 with rd_en=1 in the same cycle -> count stays 16, overflow stays 0, and 0x55 is the last byte popped.
REQ-035 Apply 300 recv_error strobes, including one cycle with received=1 -> err_count=255 (saturated), count unchanged, overflow=0; then clear_flags -> err_count=0.
REQ-036 Load 5 bytes, assert rst_n=0 between clk edges -> count=0 and empty=1 immediately; after release, write 0x7E -> rd_data=0x7E, count=1.
REQ-037 Drive rd_en continuously while empty with a write every 4 cycles -> each byte is popped exactly once, and count never exceeds 1 or underflows.
